// File: rtl/vfpu_result_buffer.sv
// Result FIFO behind the VFPU: buffers normalised results, issues operand credits so
// every in-flight result has a guaranteed slot, and tracks completion of a job of len_i results.
module vfpu_result_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  result_valid_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  job_done_o,
  output logic                  err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_inflight;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_popped;
  logic                  r_err;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_start;
  logic                  w_job_active;
  logic                  w_credit_ok;
  logic [CW:0]           w_occupancy;
  logic [LEN_WIDTH-1:0]  w_issued_nxt;
  logic [LEN_WIDTH-1:0]  w_popped_nxt;

  assign w_full       = (r_count == CW'(DEPTH));
  assign out_valid_o  = (r_count != '0);
  assign out_data_o   = r_mem[r_rptr];
  assign err_o        = r_err;
  assign w_pop        = out_valid_o & out_ready_i;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign w_push       = result_valid_i & (~w_full | w_pop);
  assign w_issue      = issue_valid_i & issue_ready_o;
  assign w_start      = (r_state == S_IDLE) & start_i;
  assign w_job_active = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_occupancy  = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit_ok  = (w_occupancy < (CW + 1)'(DEPTH));
  assign w_issued_nxt = r_issued + LEN_WIDTH'(w_issue);
  assign w_popped_nxt = r_popped + LEN_WIDTH'(w_pop & w_job_active);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else if (clear_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = (len_i == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && (w_issued_nxt == r_len)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_popped_nxt >= r_len) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs, from registers only so issue_ready_o has no path from issue_valid_i
  always_comb begin
    issue_ready_o = 1'b0;
    busy_o        = 1'b0;
    job_done_o    = 1'b0;
    if (r_state != S_IDLE) busy_o = 1'b1;
    if (r_state == S_DONE) job_done_o = 1'b1;
    if ((r_state == S_RUN) && w_credit_ok && (r_issued < r_len)) issue_ready_o = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= result_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else if (clear_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      // An unexpected result never drives inflight below zero.
      if (w_issue && !result_valid_i)                             r_inflight <= r_inflight + 1'b1;
      else if (!w_issue && result_valid_i && (r_inflight != '0))  r_inflight <= r_inflight - 1'b1;
      if (result_valid_i && ((w_full && !w_pop) || (r_inflight == '0))) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
    end else if (clear_i) begin
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
    end else if (w_start) begin
      r_len    <= len_i;
      r_issued <= '0;
      r_popped <= '0;
    end else begin
      r_issued <= w_issued_nxt;
      r_popped <= w_popped_nxt;
    end
  end

endmodule

// File: tb/tb_vfpu_result_buffer.sv
// Bench for vfpu_result_buffer: a 3-cycle VFPU pipeline feeds random results; a queue-based
// reference model predicts every output each cycle.
module tb_vfpu_result_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 16;

  logic          clk_i;
  logic          rst_ni;
  logic          clear_i;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic          issue_valid_i;
  logic          issue_ready_o;
  logic [DW-1:0] result_i;
  logic          result_valid_i;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;
  logic          job_done_o;
  logic          err_o;

  vfpu_result_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LEN_WIDTH (LW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .len_i         (len_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .result_i      (result_i),
    .result_valid_i(result_valid_i),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .busy_o        (busy_o),
    .job_done_o    (job_done_o),
    .err_o         (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int n_dut_issues = 0;
  int n_dut_done = 0;

  // Reference model: result queue, outstanding-operation count, job progress.
  logic [DW-1:0] m_q[$];
  int            m_inflight;
  bit            m_err;
  bit            m_in_job;
  bit            m_done;
  int            m_len;
  int            m_issued;
  int            m_popped;

  // VFPU stand-in: fixed 3-cycle latency
  bit            p_v[3];
  logic [DW-1:0] p_d[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_in_job && (m_issued < m_len) && ((m_q.size() + m_inflight) < DEPTH);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_inflight = 0;
    m_err      = 0;
    m_in_job   = 0;
    m_done     = 0;
    m_len      = 0;
    m_issued   = 0;
    m_popped   = 0;
  endtask

  task automatic pipe_flush();
    for (int i = 0; i < 3; i++) begin
      p_v[i] = 0;
      p_d[i] = '0;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid_o, m_q.size() > 0);
    if (m_q.size() > 0) chk("out_data", out_data_o, m_q[0]);
    chk("issue_ready", issue_ready_o, m_ready());
    chk("busy", busy_o, m_in_job || m_done);
    chk("job_done", job_done_o, m_done);
    chk("err", err_o, m_err);
  endtask

  task automatic model_update();
    bit pop, issue, push, draining;
    issue = issue_valid_i && m_ready();
    if (clear_i) begin
      model_clear();
    end else begin
      pop  = (m_q.size() > 0) && out_ready_i;
      if (result_valid_i && (((m_q.size() == DEPTH) && !pop) || (m_inflight == 0))) m_err = 1;
      push = result_valid_i && ((m_q.size() < DEPTH) || pop);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(result_i);
      m_inflight = m_inflight + (issue ? 1 : 0) - (result_valid_i ? 1 : 0);
      if (m_inflight < 0) m_inflight = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_in_job) begin
        if (start_i) begin
          if (len_i == 0) m_done = 1;
          else begin
            m_in_job = 1;
            m_len    = int'(len_i);
            m_issued = 0;
            m_popped = 0;
          end
        end
      end else begin
        draining = (m_issued == m_len);
        if (issue) m_issued++;
        if (pop)   m_popped++;
        if (draining && (m_popped >= m_len)) begin
          m_in_job = 0;
          m_done   = 1;
        end
      end
    end
    p_v[2] = p_v[1]; p_d[2] = p_d[1];
    p_v[1] = p_v[0]; p_d[1] = p_d[0];
    p_v[0] = issue;  p_d[0] = $urandom();
  endtask

  task automatic cycle();
    @(negedge clk_i);
    check_outputs();
    if (issue_valid_i && issue_ready_o) n_dut_issues++;
    if (job_done_o) n_dut_done++;
    model_update();
    @(posedge clk_i);
    #1;
    start_i        = 1'b0;
    clear_i        = 1'b0;
    result_valid_i = p_v[2];
    result_i       = p_d[2];
  endtask

  initial begin
    int d0;
    int i0;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    issue_valid_i = 1'b0; result_i = '0; result_valid_i = 1'b0; out_ready_i = 1'b0;
    model_clear();
    pipe_flush();

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_issue_ready", issue_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_job_done", job_done_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    cycle();

    // Job of 4, consumer always ready
    d0 = n_dut_done;
    len_i = 16'd4; start_i = 1'b1; issue_valid_i = 1'b1; out_ready_i = 1'b1;
    for (int c = 0; c < 40 && n_dut_done == d0; c++) cycle();
    chk("t1_done_pulses", n_dut_done, d0 + 1);
    chk("t1_err", err_o, 0);
    cycle();

    // Stalled consumer: credits limit issues to DEPTH
    d0 = n_dut_done;
    i0 = n_dut_issues;
    len_i = 16'd20; start_i = 1'b1; out_ready_i = 1'b0;
    repeat (15) cycle();
    chk("t2_issues_stalled", n_dut_issues - i0, DEPTH);
    chk("t2_full_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    for (int c = 0; c < 200 && n_dut_done == d0; c++) cycle();
    chk("t2_done_pulses", n_dut_done, d0 + 1);
    chk("t2_issues_total", n_dut_issues - i0, 20);
    chk("t2_err", err_o, 0);
    cycle();

    // Full FIFO: push and pop in the same cycle, then dropped push
    len_i = 16'd8; start_i = 1'b1; out_ready_i = 1'b0;
    for (int c = 0; c < 30 && !(m_q.size() == DEPTH && m_inflight == 0); c++) cycle();
    chk("t3_ready_when_full", issue_ready_o, 0);
    out_ready_i = 1'b1; result_valid_i = 1'b1; result_i = $urandom();
    cycle();
    out_ready_i = 1'b0;
    cycle();
    result_valid_i = 1'b1; result_i = $urandom();
    repeat (4) cycle();
    chk("t4_err_sticky", err_o, 1);
    clear_i = 1'b1;
    cycle();
    chk("t4_clear_err", err_o, 0);
    chk("t4_clear_valid", out_valid_o, 0);
    chk("t4_clear_data", out_data_o, 0);
    chk("t4_clear_busy", busy_o, 0);
    cycle();

    // Zero-length job
    d0 = n_dut_done;
    i0 = n_dut_issues;
    len_i = '0; start_i = 1'b1; issue_valid_i = 1'b1;
    repeat (4) cycle();
    chk("t5_done_pulses", n_dut_done, d0 + 1);
    chk("t5_no_issue", n_dut_issues, i0);

    // Asynchronous reset mid-job with 3 results buffered
    len_i = 16'd10; start_i = 1'b1; out_ready_i = 1'b0;
    for (int c = 0; c < 20 && m_q.size() < 3; c++) cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_out_valid", out_valid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_issue_ready", issue_ready_o, 0);
    chk("t6_out_data", out_data_o, 0);
    model_clear();
    pipe_flush();
    issue_valid_i = 1'b0; result_valid_i = 1'b0; result_i = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycle();

    // Random jobs with random feeder/consumer back-pressure
    for (int j = 0; j < 6; j++) begin
      d0 = n_dut_done;
      len_i = LW'($urandom_range(1, 30));
      start_i = 1'b1;
      for (int c = 0; c < 800 && n_dut_done == d0; c++) begin
        issue_valid_i = 1'($urandom_range(0, 1));
        out_ready_i   = ($urandom_range(0, 3) != 0);
        cycle();
      end
      chk("t7_done_pulses", n_dut_done, d0 + 1);
      issue_valid_i = 1'b0;
      cycle();
    end
    chk("t7_err", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
